instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage upstream of the control/decode unit. Holds the PC and fetches instructions
//  over a req/gnt/rvalid instruction-memory port. Presents Instr to decode with a valid flag.
//  Advances the PC to PC+4, or to PC+ImmOp when decode asserts PCsrc (taken beq).
//  One instruction in flight at a time. No prediction, no prefetch.
// PARAMETERS
//  ADDR_WIDTH  32            PC and imem address width
//  RESET_PC    32'h00000000  PC loaded on reset
//  NOP_INSTR   32'h00000013  Instr value while no valid instruction (addi x0,x0,0)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  PCsrc        in   1           from control: take branch; sampled only at retire
//  ImmOp        in   ADDR_WIDTH  sign-extended branch offset from the imm-extend unit
//  instr_ready  in   1           consumer done with current Instr (execute complete)
//  imem_req     out  1           fetch request
//  imem_addr    out  ADDR_WIDTH  fetch address; always equals PC
//  imem_gnt     in   1           request accepted (may be high in the same cycle as req)
//  imem_rvalid  in   1           read data valid; earliest the cycle after gnt
//  imem_rdata   in   32          fetched instruction
//  Instr        out  32          instruction to control/decode
//  instr_valid  out  1           Instr holds a fetched instruction
//  PC           out  ADDR_WIDTH  address of the current Instr
//  PCplus4      out  ADDR_WIDTH  PC+4, combinational, for jal/link use
//  misalign_err out  1           misaligned fetch target (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, PC=RESET_PC, imem_req=0, Instr=NOP_INSTR,
//   instr_valid=0, misalign_err=0. Reset asserted in any state aborts the fetch.
//   An imem_rvalid that arrives after reset release is ignored.
//  FSM:
//   IDLE -> REQ unconditionally, one cycle after rst_n deasserts.
//   REQ: imem_req=1, imem_addr=PC. Req and addr stay stable until imem_gnt; then go to WAIT.
//   WAIT: imem_req=0. On imem_rvalid, register Instr<=imem_rdata, set instr_valid=1, go to HOLD.
//   HOLD: Instr and instr_valid are held. On instr_ready:
//    PC <= PCsrc ? PC+ImmOp : PC+4; instr_valid<=0; Instr<=NOP_INSTR; go to REQ.
//   TRAP (macro only): imem_req=0, instr_valid=0. Exits only on reset.
//  Minimum latency: REQ(gnt) -> WAIT(rvalid) -> HOLD is 3 cycles per instruction
//   when instr_ready is high in the first HOLD cycle.
//  Any imem_rvalid outside WAIT is a protocol violation: ignore it, no state change.
//  instr_ready outside HOLD is ignored. PCsrc/ImmOp are don't-care outside the HOLD retire cycle.
//  PC arithmetic is modulo 2^ADDR_WIDTH: 0xFFFFFFFC+4 = 0x0 and PC+ImmOp wraps silently.
//   ImmOp is two's complement.
//  Simultaneous rvalid and gnt cannot occur (one outstanding request). If they do,
//   the gnt is handled per REQ and rvalid is ignored.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined:
//   - At retire, if the next PC has [1:0]!=0, load PC with that value,
//     set misalign_err=1 (sticky), and go to TRAP. No request is issued.
//  Not defined:
//   - misalign_err is tied to 0.
//   - imem_addr = {PC[ADDR_WIDTH-1:2],2'b00}.
//   - PC keeps its computed value and never enters TRAP.
// TESTING
//  1 Reset then release: cycle 1 imem_req=0, cycle 2 imem_req=1 with imem_addr=0x0;
//    instr_valid=0 and Instr=0x00000013 throughout.
//  2 Sequential: gnt immediate, rvalid next cycle with 0x00A00093, instr_ready=1 ->
//    Instr=0x00A00093 valid one cycle; next req addr=0x4; PCplus4=0x8 at PC=0x4.
//  3 Branch: at PC=0x10 with PCsrc=1, ImmOp=0xFFFFFFF8 on retire -> next imem_addr=0x08.
//    Same with PCsrc=0 -> next imem_addr=0x14.
//  4 Backpressure: gnt held low 3 cycles -> req and addr stable; rvalid in REQ ignored;
//    instr_ready low 4 cycles in HOLD -> Instr and PC unchanged.
//  5 Wrap: PC=0xFFFFFFFC, retire with PCsrc=0 -> next imem_addr=0x0.
//  6 rst_n pulsed low in WAIT, then rvalid -> IDLE, rvalid ignored, refetch from RESET_PC.
//    With macro: PCsrc=1, ImmOp=0x2 at PC=0x0 -> misalign_err=1 and no further imem_req.

Source files
------------

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage: req/gnt/rvalid imem port, PC update at retire.
// Optional FETCH_MISALIGN_CHECK_EN traps on a misaligned next PC instead of fetching it.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         PCsrc,
  input  logic signed [ADDR_WIDTH-1:0] ImmOp,
  input  logic                         instr_ready,
  output logic                         imem_req,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  input  logic                         imem_gnt,
  input  logic                         imem_rvalid,
  input  logic [31:0]                  imem_rdata,
  output logic [31:0]                  Instr,
  output logic                         instr_valid,
  output logic [ADDR_WIDTH-1:0]        PC,
  output logic [ADDR_WIDTH-1:0]        PCplus4,
  output logic                         misalign_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, TRAP} state_t;

  state_t                  state, state_nx;
  logic                    retire;
  logic                    misalign;
  logic [ADDR_WIDTH-1:0]   pc_target;

  // Modulo-2^ADDR_WIDTH next-PC; the two's complement offset wraps naturally.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(
    input logic [ADDR_WIDTH-1:0]        pc,
    input logic                         take,
    input logic signed [ADDR_WIDTH-1:0] imm
  );
    next_pc = take ? (pc + $unsigned(imm)) : (pc + ADDR_WIDTH'(4));
  endfunction

  assign PCplus4   = PC + ADDR_WIDTH'(4);
  assign pc_target = next_pc(PC, PCsrc, ImmOp);
  assign retire    = (state == HOLD) && instr_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign  = (pc_target[1:0] != 2'b00);
  assign imem_addr = PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_err <= 1'b0;
    else if (retire && misalign)
      misalign_err <= 1'b1;
  end
`else
  assign misalign     = 1'b0;
  assign imem_addr    = {PC[ADDR_WIDTH-1:2], 2'b00};
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Stray rvalid outside WAIT (including alongside gnt in REQ) is deliberately ignored.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_nx = WAIT;
      end
      WAIT: if (imem_rvalid) state_nx = HOLD;
      HOLD: if (instr_ready) state_nx = misalign ? TRAP : REQ;
      TRAP: state_nx = TRAP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC          <= RESET_PC;
      Instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if ((state == WAIT) && imem_rvalid) begin
      Instr       <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (retire) begin
      PC          <= pc_target;
      Instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end
  end

endmodule
